// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Purpose : Shared types and parameter defaults for the memory-port arbiter.
//           Holds the read-return tag encoding and the default data width,
//           RAM address width and MEM-stage burst limit.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int ARQ_DEFAULT              = 16;
  localparam int MEMORY_ADDR_SIZE_DEFAULT = 13;
  localparam int MAX_MEM_BURST_DEFAULT    = 4;

  // Identifies which requester owns the RAM read data arriving this cycle.
  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_IF   = 2'd1,
    RET_MEM  = 2'd2
  } ret_tag_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Arbitrates a single-port synchronous RAM between an instruction
//           fetch port and a MEM-stage load/store port. One access per cycle,
//           MEM stage has priority; read data returns one cycle after grant.
//           Optional fairness (macro RSA_ARB_FAIR_EN) forces a fetch grant
//           after MAX_MEM_BURST consecutive MEM grants while fetch waits.
// Ports   : clk, rst (sync, active-high)
//           if_req/if_addr -> if_gnt, if_rvalid, if_rdata, stall_if
//           mem_rd_req/mem_wr_req/mem_addr/mem_wdata
//             -> mem_gnt, mem_rvalid, mem_rdata, stall_mem
//           err_rdwr : sticky, rd and wr requested together
//           ram_en/ram_we/ram_addr/ram_wdata -> RAM, ram_rdata <- RAM
// Config  : `define RSA_ARB_FAIR_EN enables the fetch starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ARQ              = ARQ_DEFAULT,
  parameter int MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEFAULT,
  parameter int MAX_MEM_BURST    = MAX_MEM_BURST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req,
  input  logic [MEMORY_ADDR_SIZE-1:0] if_addr,
  output logic                        if_gnt,
  output logic                        if_rvalid,
  output logic [ARQ-1:0]              if_rdata,
  input  logic                        mem_rd_req,
  input  logic                        mem_wr_req,
  input  logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  input  logic [ARQ-1:0]              mem_wdata,
  output logic                        mem_gnt,
  output logic                        mem_rvalid,
  output logic [ARQ-1:0]              mem_rdata,
  output logic                        stall_if,
  output logic                        stall_mem,
  output logic                        err_rdwr,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [MEMORY_ADDR_SIZE-1:0] ram_addr,
  output logic [ARQ-1:0]              ram_wdata,
  input  logic [ARQ-1:0]              ram_rdata
);

  logic     mem_req;
  logic     force_if;
  logic     grant_mem;
  logic     grant_if;
  ret_tag_t ret_tag;
  ret_tag_t ret_tag_nxt;

  assign mem_req = mem_rd_req | mem_wr_req;

`ifdef RSA_ARB_FAIR_EN
  localparam int CNT_W = $clog2(MAX_MEM_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_MEM_BURST);

  // Consecutive MEM grants issued while fetch was waiting.
  logic [CNT_W-1:0] burst_cnt;

  assign force_if = if_req && (burst_cnt == BURST_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (!if_req || grant_if) begin
      burst_cnt <= '0;
    end else if (grant_mem && (burst_cnt != BURST_LIMIT)) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are suppressed while rst is high so nothing reaches the RAM
  // during the reset cycle.
  assign grant_mem = !rst && mem_req && !force_if;
  assign grant_if  = !rst && if_req && !grant_mem;

  assign if_gnt    = grant_if;
  assign mem_gnt   = grant_mem;
  assign stall_if  = if_req && !grant_if;
  assign stall_mem = mem_req && !grant_mem;

  // A simultaneous rd+wr is treated as a write, so mem_wr_req alone decides.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_mem) begin
      ram_en   = 1'b1;
      ram_addr = mem_addr;
      if (mem_wr_req) begin
        ram_we    = 1'b1;
        ram_wdata = mem_wdata;
      end
    end else if (grant_if) begin
      ram_en   = 1'b1;
      ram_addr = if_addr;
    end
  end

  always_comb begin
    ret_tag_nxt = RET_NONE;
    if (grant_if) begin
      ret_tag_nxt = RET_IF;
    end else if (grant_mem && !mem_wr_req) begin
      ret_tag_nxt = RET_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_tag  <= RET_NONE;
      err_rdwr <= 1'b0;
    end else begin
      ret_tag  <= ret_tag_nxt;
      err_rdwr <= err_rdwr | (mem_rd_req & mem_wr_req);
    end
  end

  // Returns are also masked by rst so a read granted just before reset
  // never shows up as valid data.
  assign if_rvalid  = !rst && (ret_tag == RET_IF);
  assign mem_rvalid = !rst && (ret_tag == RET_MEM);
  assign if_rdata   = if_rvalid  ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;

endmodule : mem_port_arbiter
`default_nettype wire
